// File: rtl/morse_rx.sv
// morse_rx: Morse receiver. Samples an on/off keyed line, measures mark and
// space run lengths in units of PRESCALER clocks and decodes each letter to
// uppercase ASCII (A-Z, 0-9), with "?" plus err for undecodable patterns and
// a single " " per word gap.
// Optional macro MORSE_RX_SYNC_EN: inserts a 2-flop synchronizer ahead of the
// sampling register for an asynchronous morse_in (adds 2 cycles of latency).
module morse_rx #(
    parameter int unsigned PRESCALER = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       morse_in,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    output logic       err
);

    localparam int unsigned RUN_MAX = 8 * PRESCALER;
    localparam int unsigned RW      = $clog2(RUN_MAX + 1);
    localparam logic [RW-1:0] RUN_SAT = RW'(RUN_MAX);
    localparam logic [RW-1:0] TH_LTR  = RW'(2 * PRESCALER);
    localparam logic [RW-1:0] TH_WORD = RW'(5 * PRESCALER);

    typedef enum logic [2:0] {WAIT_LOW, IDLE, MARK, SPACE, GAP} state_t;

    state_t        state_q;
    logic          line;
    logic          s_q;
    logic          s_prev_q;
    logic [RW-1:0] run_q;
    logic [RW-1:0] run_d;
    logic [4:0]    elem_q;
    logic [2:0]    cnt_q;
    logic          ovf_q;
    logic [7:0]    letter;

`ifdef MORSE_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer for an asynchronous keyed line
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[0], morse_in};
    end

    assign line = sync_q[1];
`else
    assign line = morse_in;
`endif

    // Input sample and its one-cycle history; left unreset so that a mark held
    // through reset is visible immediately after release (WAIT_LOW relies on it)
    always_ff @(posedge clk) begin
        s_q      <= line;
        s_prev_q <= s_q;
    end

    // Length of the current run of s_q including this cycle, saturating
    always_comb begin
        if (s_q != s_prev_q) begin
            run_d = RW'(1);
        end else if (run_q == RUN_SAT) begin
            run_d = run_q;
        end else begin
            run_d = run_q + RW'(1);
        end
    end

    // Run counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    // Pattern lookup keyed by (length, pattern); dot = 0, dash = 1, first
    // element in the MSB of the used length
    function automatic logic [7:0] decode(input logic [2:0] n, input logic [4:0] p);
        logic [7:0] c;
        case ({n, p})
            {3'd1, 5'b00000}: c = "E";
            {3'd1, 5'b00001}: c = "T";
            {3'd2, 5'b00000}: c = "I";
            {3'd2, 5'b00001}: c = "A";
            {3'd2, 5'b00010}: c = "N";
            {3'd2, 5'b00011}: c = "M";
            {3'd3, 5'b00000}: c = "S";
            {3'd3, 5'b00001}: c = "U";
            {3'd3, 5'b00010}: c = "R";
            {3'd3, 5'b00011}: c = "W";
            {3'd3, 5'b00100}: c = "D";
            {3'd3, 5'b00101}: c = "K";
            {3'd3, 5'b00110}: c = "G";
            {3'd3, 5'b00111}: c = "O";
            {3'd4, 5'b00000}: c = "H";
            {3'd4, 5'b00001}: c = "V";
            {3'd4, 5'b00010}: c = "F";
            {3'd4, 5'b00100}: c = "L";
            {3'd4, 5'b00110}: c = "P";
            {3'd4, 5'b00111}: c = "J";
            {3'd4, 5'b01000}: c = "B";
            {3'd4, 5'b01001}: c = "X";
            {3'd4, 5'b01010}: c = "C";
            {3'd4, 5'b01011}: c = "Y";
            {3'd4, 5'b01100}: c = "Z";
            {3'd4, 5'b01101}: c = "Q";
            {3'd5, 5'b00000}: c = "5";
            {3'd5, 5'b00001}: c = "4";
            {3'd5, 5'b00011}: c = "3";
            {3'd5, 5'b00111}: c = "2";
            {3'd5, 5'b01111}: c = "1";
            {3'd5, 5'b11111}: c = "0";
            {3'd5, 5'b10000}: c = "6";
            {3'd5, 5'b11000}: c = "7";
            {3'd5, 5'b11100}: c = "8";
            {3'd5, 5'b11110}: c = "9";
            default:          c = 8'h3F;
        endcase
        return c;
    endfunction

    // Character to report when the letter gap completes
    always_comb begin
        letter = ovf_q ? 8'h3F : decode(cnt_q, elem_q);
    end

    // Receiver FSM with registered character/valid/err outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_LOW;
            elem_q      <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            ascii_out   <= 8'h00;
            ascii_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            ascii_valid <= 1'b0;
            err         <= 1'b0;
            case (state_q)
                WAIT_LOW: if (!s_q) state_q <= IDLE;
                IDLE:     if (s_q) state_q <= MARK;
                MARK: begin
                    if (!s_q) begin
                        if (cnt_q == 3'd5) begin
                            ovf_q <= 1'b1;
                        end else begin
                            elem_q <= {elem_q[3:0], (run_q >= TH_LTR)};
                            cnt_q  <= cnt_q + 3'd1;
                        end
                        state_q <= SPACE;
                    end
                end
                SPACE: begin
                    if (s_q) begin
                        state_q <= MARK;
                    end else if (run_d == TH_LTR) begin
                        ascii_out   <= letter;
                        ascii_valid <= 1'b1;
                        err         <= (letter == 8'h3F);
                        elem_q      <= '0;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                        state_q     <= GAP;
                    end
                end
                GAP: begin
                    if (s_q) begin
                        state_q <= MARK;
                    end else if (run_d == TH_WORD) begin
                        ascii_out   <= 8'h20;
                        ascii_valid <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= WAIT_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_rx.sv
// tb_morse_rx: directed Morse stimulus with a run-length model of the receiver.
// Each driven run (level, length) is interpreted at the letter/word level to
// predict which characters appear and on which cycle; a compare process checks
// every cycle against those predictions.
module tb_morse_rx;

    localparam int unsigned P = 100;
`ifdef MORSE_RX_SYNC_EN
    localparam int unsigned LAT = 3;
`else
    localparam int unsigned LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       morse_in;
    logic [7:0] ascii_out;
    logic       ascii_valid;
    logic       err;

    morse_rx #(.PRESCALER(P)) dut (
        .clk(clk), .rst(rst), .morse_in(morse_in),
        .ascii_out(ascii_out), .ascii_valid(ascii_valid), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  ch;
        logic        e;
    } exp_t;

    exp_t        expq[$];
    int          tests = 0;
    int          fails = 0;
    int          nvalid = 0;
    int          nerr = 0;
    int unsigned last_valid_cyc = 0;
    logic [7:0]  last_char = 8'h00;
    bit          chk_en = 0;
    string       rx = "";

    // model state
    string m_pend = "";
    bit    m_ovf = 0;
    bit    m_waitlow = 1;

    string alnum = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
    string tbl[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                       ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                       "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                       "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                       "--...", "---..", "----."};

    function automatic logic [8:0] mdecode(input string s);
        for (int i = 0; i < 36; i++)
            if (tbl[i] == s) return {1'b0, alnum[i]};
        return {1'b1, 8'h3F};
    endfunction

    function automatic string code_of(input byte c);
        for (int i = 0; i < 36; i++)
            if (alnum[i] == c) return tbl[i];
        return "";
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic check_str(input string name, input string req);
        tests++;
        if (rx != req) begin
            fails++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, rx, req);
        end
    endtask

    // drive one run of level v for n cycles and predict its consequences
    task automatic run(input bit v, input int unsigned n);
        logic [8:0] dec;
        exp_t x;
        morse_in = v;
        if (v) begin
            if (!m_waitlow) begin
                if (m_pend.len() == 5) m_ovf = 1;
                else if (n < 2 * P) m_pend = {m_pend, "."};
                else m_pend = {m_pend, "-"};
            end
        end else begin
            m_waitlow = 0;
            if (m_pend.len() != 0 && n >= 2 * P) begin
                dec = m_ovf ? {1'b1, 8'h3F} : mdecode(m_pend);
                x.cyc = cyc + LAT + 2 * P; x.ch = dec[7:0]; x.e = dec[8];
                expq.push_back(x);
                m_pend = ""; m_ovf = 0;
                if (n >= 5 * P) begin
                    x.cyc = cyc + LAT + 5 * P; x.ch = 8'h20; x.e = 1'b0;
                    expq.push_back(x);
                end
            end
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic send_text(input string s);
        string pat;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == " ") continue;
            pat = code_of(s[i]);
            for (int j = 0; j < pat.len(); j++) begin
                run(1'b1, (pat[j] == "-") ? 3 * P : P);
                if (j < pat.len() - 1) run(1'b0, P);
            end
            if (i == s.len() - 1) run(1'b0, 4 * P);
            else if (s[i + 1] == " ") run(1'b0, 7 * P);
            else run(1'b0, 3 * P);
        end
    endtask

    task automatic reset_pulse(input int unsigned n);
        rst = 1'b1;
        chk_en = 0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        expq.delete();
        m_pend = ""; m_ovf = 0; m_waitlow = 1;
        last_char = 8'h00;
        check("reset ascii_out", ascii_out, 8'h00);
        check("reset ascii_valid", ascii_valid, 0);
        check("reset err", err, 0);
        chk_en = 1;
    endtask

    // per-cycle comparison against the model's predictions
    always @(negedge clk) begin
        if (chk_en) begin
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                tests++; fails++;
                $display("FAIL stream: no ascii_valid at cycle %0d, expected char 0x%0h", expq[0].cyc, expq[0].ch);
                void'(expq.pop_front());
            end
            tests++;
            if (ascii_valid) begin
                nvalid++;
                last_valid_cyc = cyc;
                if (err) nerr++;
                rx = $sformatf("%s%c", rx, ascii_out);
                if (expq.size() == 0 || expq[0].cyc != cyc) begin
                    fails++;
                    $display("FAIL stream: unexpected ascii_valid at cycle %0d with char 0x%0h err %0b", cyc, ascii_out, err);
                    last_char = ascii_out;
                end else begin
                    if (ascii_out !== expq[0].ch || err !== expq[0].e) begin
                        fails++;
                        $display("FAIL stream: cycle %0d got char 0x%0h err %0b, expected char 0x%0h err %0b",
                                 cyc, ascii_out, err, expq[0].ch, expq[0].e);
                    end
                    last_char = expq[0].ch;
                    void'(expq.pop_front());
                end
            end else if (err !== 1'b0 || ascii_out !== last_char) begin
                fails++;
                $display("FAIL hold: cycle %0d got char 0x%0h err %0b, expected char 0x%0h err 0",
                         cyc, ascii_out, err, last_char);
            end
        end
    end

    initial begin
        int unsigned d;
        int e0;
        rst = 1'b1;
        morse_in = 1'b1;
        @(negedge clk);
        reset_pulse(3);

        // mark in progress at reset release is discarded
        nvalid = 0;
        run(1'b1, 3 * P);
        run(1'b0, 8 * P);
        check("waitlow no output", nvalid, 0);

        // full message with word gaps
        rx = "";
        send_text("CARS ARE RED");
        check_str("message", "CARS ARE RED");
        check("message err count", nerr, 0);

        // single dot latency
        rx = "";
        run(1'b1, P);
        d = cyc;
        run(1'b0, 3 * P);
        check("E latency", last_valid_cyc - d, (LAT == 1) ? 201 : 203);
        check("E char", ascii_out, 8'h45);

        // mark length threshold
        rx = "";
        run(1'b1, 199); run(1'b0, 3 * P);
        run(1'b1, 200); run(1'b0, 3 * P);
        check_str("mark threshold", "ET");

        // gap length threshold
        rx = "";
        run(1'b1, P); run(1'b0, P); run(1'b1, P); run(1'b0, 199);
        run(1'b1, 3 * P); run(1'b0, 3 * P);
        check_str("gap 199", "U");
        rx = "";
        run(1'b1, P); run(1'b0, P); run(1'b1, P); run(1'b0, 200);
        run(1'b1, 3 * P); run(1'b0, 3 * P);
        check_str("gap 200", "IT");

        // element overflow then recovery
        rx = "";
        e0 = nerr;
        repeat (5) begin run(1'b1, P); run(1'b0, P); end
        run(1'b1, P); run(1'b0, 3 * P);
        check("overflow char", ascii_out, 8'h3F);
        run(1'b1, 3 * P); run(1'b0, 3 * P);
        check_str("overflow stream", "?T");
        check("overflow err count", nerr - e0, 1);

        // reset mid-character discards partial M
        rx = "";
        run(1'b1, 3 * P); run(1'b0, P); run(1'b1, 3 * P); run(1'b0, 50);
        morse_in = 1'b0;
        reset_pulse(1);
        run(1'b0, 3 * P);
        run(1'b1, 3 * P); run(1'b0, P); run(1'b1, P); run(1'b0, 3 * P);
        check_str("reset mid-char", "N");

        repeat (10) @(negedge clk);
        check("leftover expectations", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/morse_rx.md
Name: morse_rx

Overview:
- Morse receiver: samples a single-bit on/off keyed line and decodes it into ASCII characters, one character per valid pulse.
- Pairs with morse_tx at the far end of the Morse link. It uses the same unit timing: one unit = PRESCALER clocks, dot = 1 unit, dash = 3, element gap = 1, letter gap = 3, word gap = 7.
- Downstream logic (UART bridge, display, loopback checker) consumes ascii_out/ascii_valid.

Parameters:
- PRESCALER, 50_000_000, clocks per Morse unit; must match the transmitter. Legal range 2..2^24.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- morse_in  input  1  keyed line; 1 = mark (tone on), 0 = space
- ascii_out  output  8  decoded character; held until next ascii_valid
- ascii_valid  output  1  one-cycle pulse; ascii_out is valid in this cycle
- err  output  1  one-cycle pulse coincident with ascii_valid when ascii_out = "?" due to an undecodable pattern

Behaviour:
- One clock, synchronous active-high reset on clk.
- Reset values:
  - ascii_out = 8'h00, ascii_valid = 0, err = 0.
  - Run counter, element count and element shift register all cleared.
  - State = WAIT_LOW.
- Sampling: morse_in is registered once (s_in); all timing below is in cycles of s_in.
- Run counter: counts consecutive cycles of equal s_in, resets to 1 on each change of s_in, saturates at 8*PRESCALER. Width is clog2(8*PRESCALER+1).
- States:
  - WAIT_LOW: ignore marks. Go to IDLE once s_in = 0. Prevents decoding a mark that was in progress at reset release.
  - IDLE: line low, nothing pending. s_in = 1 -> MARK.
  - MARK: line high. On s_in falling to 0, classify the run length L:
    - L < 2*PRESCALER -> dot (bit 0); otherwise -> dash (bit 1). Marks saturating at 8 units are dashes.
    - Shift the bit into the 5-bit element register (first element ends up MSB of the used length).
    - Increment the element count; a 6th element sets the sticky overflow flag instead.
    - Go to SPACE.
  - SPACE: line low, elements pending.
    - s_in = 1 before 2*PRESCALER low cycles -> MARK (element gap).
    - The low run reaching exactly 2*PRESCALER cycles -> emit letter, clear the element register/count/overflow, go to GAP.
  - GAP: letter emitted, line low.
    - The low run reaching exactly 5*PRESCALER cycles -> emit " " (8'h20), go to IDLE.
    - s_in = 1 before that -> MARK with no space emitted.
- Emit timing: ascii_valid rises on the cycle the low-run threshold is hit. The letter is therefore reported 2*PRESCALER cycles after the first low sample, plus 1 cycle for the input register.
- Decode table, keyed by (length, pattern):
  - A-Z and 0-9, standard ITU patterns, output as uppercase ASCII.
  - Any other pattern, or overflow set -> "?" (8'h3F) with err = 1.
- At most one space per word gap. IDLE never emits, so a long idle line produces no repeated spaces. No space is emitted before the first letter after reset.
- Reset asserted mid-character: the partial character is discarded, no pulse is produced, and the block returns to WAIT_LOW.
- ascii_valid and err are never asserted in consecutive cycles.

Optional Feature:
- Macro: MORSE_RX_SYNC_EN.
- Defined: morse_in passes through a 2-flop synchronizer ahead of the s_in register, adding 2 cycles of latency; thresholds are unchanged. Required when morse_in is asynchronous, e.g. a key or external pin.
- Undefined: only the single s_in register; morse_in must be synchronous to clk.

Test Plan:
- Reset release with morse_in = 1, high for 3 units, then low for 8 units -> no ascii_valid at all (WAIT_LOW discard).
- PRESCALER=100, morse_tx driving morse_in with "CARS ARE RED" -> ascii_valid sequence C,A,R,S,20h,A,R,E,20h,R,E,D; err never 1; exactly one space per word gap.
- Single dot, then low -> ascii_out = "E" (45h) with ascii_valid exactly 201 cycles after the falling edge at morse_in (203 with MORSE_RX_SYNC_EN).
- Threshold edges at PRESCALER=100:
  - Mark of 199 cycles -> dot; mark of 200 cycles -> dash.
  - Low gap of 199 cycles -> same letter (".." + "-" decodes "U"); low gap of 200 cycles -> letters split ("I" then "T").
- Six dots back to back -> ascii_out = 3Fh with err = 1 for the same cycle; the next letter "T" decodes correctly.
- rst pulsed for 1 cycle after two dashes of an "M" -> no output for that pattern; a fresh "-." after the line is low decodes "N".
